// File: rtl/xaui_link_ctrl.sv
// Bring-up and supervision sequencer for a four-lane XAUI PHY: MGT reset, comma
// alignment, channel bonding, then live-link monitoring with automatic retrain.
module xaui_link_ctrl #(
    parameter int unsigned RESET_CYCLES  = 16,
    parameter int unsigned LOCK_TIMEOUT  = 4096,
    parameter int unsigned ALIGN_GOOD    = 64,
    parameter int unsigned ALIGN_TIMEOUT = 4096,
    parameter int unsigned SYNC_TIMEOUT  = 4096,
    parameter int unsigned ERR_LIMIT     = 8
) (
    input  logic       mgt_clk,
    input  logic       reset_n,
    input  logic       cfg_powerdown,
    input  logic       cfg_loopback,
    input  logic       force_retrain,
    input  logic [3:0] mgt_rxlock,
    input  logic [7:0] mgt_code_valid,
    input  logic [3:0] mgt_syncok,
    input  logic [3:0] mgt_rxbufferr,
    output logic [3:0] mgt_tx_reset,
    output logic [3:0] mgt_rx_reset,
    output logic [3:0] mgt_enable_align,
    output logic       mgt_en_chan_sync,
    output logic       mgt_loopback,
    output logic       mgt_powerdown,
    output logic       link_up,
    output logic [2:0] link_state,
    output logic [7:0] retry_count
);

    typedef enum logic [2:0] {
        S_PD        = 3'd0,
        S_RST       = 3'd1,
        S_WAIT_LOCK = 3'd2,
        S_ALIGN     = 3'd3,
        S_SYNC      = 3'd4,
        S_UP        = 3'd5
    } state_t;

    localparam logic [15:0] L_RST_LAST   = 16'(RESET_CYCLES - 1);
    localparam logic [15:0] L_LOCK_LAST  = 16'(LOCK_TIMEOUT - 1);
    localparam logic [15:0] L_GOOD_LAST  = 16'(ALIGN_GOOD - 1);
    localparam logic [15:0] L_ALIGN_LAST = 16'(ALIGN_TIMEOUT - 1);
    localparam logic [15:0] L_SYNC_LAST  = 16'(SYNC_TIMEOUT - 1);
    localparam logic [15:0] L_ERR_LIMIT  = 16'(ERR_LIMIT);

    state_t      r_state;
    state_t      w_next;
    logic [15:0] r_timer;
    logic [15:0] r_good;
    logic [15:0] r_err;
    logic [7:0]  r_retry;
    logic        r_loopback;
    logic [3:0]  r_tx_reset;
    logic [3:0]  r_rx_reset;
    logic [3:0]  r_align;
    logic        r_chan_sync;
    logic        r_powerdown;
    logic        r_link_up;
    logic        w_retry;
    logic        w_restart;
    logic        w_all_valid;
    logic        w_up_fatal;

    assign w_all_valid = &mgt_code_valid;
    // The error counter is compared registered, so a burst of ERR_LIMIT errors drops the link one edge after the last one.
    assign w_up_fatal  = !(&mgt_rxlock) || !(&mgt_syncok) || (|mgt_rxbufferr) || (r_err == L_ERR_LIMIT);

    always_comb begin
        w_next    = r_state;
        w_retry   = 1'b0;
        w_restart = 1'b0;
        if (cfg_powerdown) begin
            w_next = S_PD;
        end else if (r_state == S_PD) begin
            w_next = S_RST;
        end else if (r_state == S_RST) begin
            if (force_retrain)
                w_restart = 1'b1;
            else if (r_timer == L_RST_LAST)
                w_next = S_WAIT_LOCK;
        end else if (force_retrain || (cfg_loopback != r_loopback)) begin
            w_next = S_RST;
        end else begin
            case (r_state)
                S_WAIT_LOCK: begin
                    if (&mgt_rxlock) begin
                        w_next = S_ALIGN;
                    end else if (r_timer == L_LOCK_LAST) begin
                        w_next  = S_RST;
                        w_retry = 1'b1;
                    end
                end
                S_ALIGN: begin
                    if (w_all_valid && (r_good == L_GOOD_LAST)) begin
                        w_next = S_SYNC;
                    end else if (r_timer == L_ALIGN_LAST) begin
                        w_next  = S_RST;
                        w_retry = 1'b1;
                    end
                end
                S_SYNC: begin
                    if (&mgt_syncok) begin
                        w_next = S_UP;
                    end else if (r_timer == L_SYNC_LAST) begin
                        w_next  = S_RST;
                        w_retry = 1'b1;
                    end
                end
                S_UP: begin
                    if (w_up_fatal) begin
                        w_next  = S_RST;
                        w_retry = 1'b1;
                    end
                end
                default: w_next = S_RST;
            endcase
        end
    end

    always_ff @(posedge mgt_clk or negedge reset_n) begin
        if (!reset_n) begin
            r_state     <= S_RST;
            r_timer     <= '0;
            r_good      <= '0;
            r_err       <= '0;
            r_retry     <= '0;
            r_loopback  <= 1'b0;
            r_tx_reset  <= '1;
            r_rx_reset  <= '1;
            r_align     <= '0;
            r_chan_sync <= 1'b0;
            r_powerdown <= 1'b0;
            r_link_up   <= 1'b0;
        end else begin
            r_state    <= w_next;
            r_loopback <= cfg_loopback;
            r_timer    <= ((w_next != r_state) || w_restart) ? '0 : r_timer + 16'd1;
            r_good     <= ((r_state == S_ALIGN) && (w_next == S_ALIGN) && w_all_valid) ? r_good + 16'd1 : '0;
            r_err      <= ((r_state == S_UP) && (w_next == S_UP) && !w_all_valid) ? r_err + 16'd1 : '0;
            if (w_retry && (r_retry != 8'hFF))
                r_retry <= r_retry + 8'd1;
            r_tx_reset  <= ((w_next == S_PD) || (w_next == S_RST)) ? '1 : '0;
            r_rx_reset  <= ((w_next == S_PD) || (w_next == S_RST)) ? '1 : '0;
            r_align     <= (w_next inside {S_ALIGN, S_SYNC, S_UP}) ? '1 : '0;
            r_chan_sync <= (w_next inside {S_SYNC, S_UP});
            r_powerdown <= (w_next == S_PD);
            r_link_up   <= (w_next == S_UP);
        end
    end

    assign mgt_tx_reset     = r_tx_reset;
    assign mgt_rx_reset     = r_rx_reset;
    assign mgt_enable_align = r_align;
    assign mgt_en_chan_sync = r_chan_sync;
    assign mgt_loopback     = r_loopback;
    assign mgt_powerdown    = r_powerdown;
    assign link_up          = r_link_up;
    assign link_state       = r_state;
    assign retry_count      = r_retry;

endmodule

// File: doc/xaui_link_ctrl.md
# xaui_link_ctrl

Link bring-up and supervision sequencer for one four-lane XAUI PHY instance. It sits between the MGT status/control pins and the XAUI PHY core in the 10GbE path. It sequences MGT reset, comma alignment and channel bonding, then supervises the live link and retrains automatically on loss of lock, sync or code integrity. It exports a link-up flag, its current state and a saturating retry count for software status registers.

## Interface
Parameters:
- RESET_CYCLES, 16: cycles MGT tx/rx resets are held in RST.
- LOCK_TIMEOUT, 4096: max cycles in WAIT_LOCK before retry.
- ALIGN_GOOD, 64: consecutive all-valid cycles required to leave ALIGN.
- ALIGN_TIMEOUT, 4096: max cycles in ALIGN before retry.
- SYNC_TIMEOUT, 4096: max cycles in SYNC before retry.
- ERR_LIMIT, 8: consecutive cycles with a code error in UP that force retrain.

Ports:
- mgt_clk  in  1  MGT user clock; all logic on rising edge.
- reset_n  in  1  reset, asynchronous assert, active-low.
- cfg_powerdown  in  1  level; request lane powerdown.
- cfg_loopback  in  1  level; requested MGT loopback.
- force_retrain  in  1  single-cycle pulse; restart bring-up.
- mgt_rxlock  in  4  per-lane CDR lock.
- mgt_code_valid  in  8  per-byte code valid (2 bytes/lane).
- mgt_syncok  in  4  per-lane channel-bond done.
- mgt_rxbufferr  in  4  per-lane elastic buffer error.
- mgt_tx_reset  out  4  per-lane TX reset.
- mgt_rx_reset  out  4  per-lane RX reset.
- mgt_enable_align  out  4  per-lane comma align enable.
- mgt_en_chan_sync  out  1  channel-bond enable.
- mgt_loopback  out  1  registered copy of cfg_loopback.
- mgt_powerdown  out  1  MGT powerdown.
- link_up  out  1  link in UP state.
- link_state  out  3  encoded state.
- retry_count  out  8  failed-attempt counter, saturating.

## Operation
- States and encodings: PD=0, RST=1, WAIT_LOCK=2, ALIGN=3, SYNC=4, UP=5. The FSM resets to RST.
- One 16-bit timer. It clears on every state entry and increments each cycle in that state.
- PD: mgt_powerdown=1, tx/rx reset=4'hF, align=0, chan_sync=0. Exit to RST one cycle after cfg_powerdown falls.
- RST: tx/rx reset=4'hF. After exactly RESET_CYCLES cycles, go to WAIT_LOCK.
- WAIT_LOCK: resets=0. If mgt_rxlock==4'hF, go to ALIGN. If the timer reaches LOCK_TIMEOUT-1 first, go to RST and count a retry.
- ALIGN: enable_align=4'hF. A good-run counter increments while code_valid==8'hFF and clears otherwise. When it reaches ALIGN_GOOD, go to SYNC. ALIGN_TIMEOUT expiry goes to RST and counts a retry.
- SYNC: enable_align=4'hF, en_chan_sync=1. If syncok==4'hF, go to UP. SYNC_TIMEOUT expiry goes to RST and counts a retry.
- UP: link_up=1, enable_align=4'hF, en_chan_sync=1. Any of the following causes an immediate transition to RST with a retry counted:
  - any rxlock bit low;
  - syncok!=4'hF;
  - rxbufferr!=0.
- UP error counter: increments on any cycle with code_valid!=8'hFF and clears on an all-valid cycle. Reaching ERR_LIMIT goes to RST and counts a retry.
- Transition priority, highest first:
  1. reset_n;
  2. cfg_powerdown=1 (go to PD from any state; no retry);
  3. force_retrain, or cfg_loopback differing from the registered mgt_loopback (go to RST from any non-PD, non-RST state; no retry; mgt_loopback updates on the same edge);
  4. progress condition;
  5. timeout/error.
- force_retrain while in RST restarts the RST timer.
- retry_count increments by 1 per counted failure and saturates at 8'hFF. Only reset_n clears it.
- Simultaneous progress condition and timeout in the same cycle: progress wins.

## Timing
- All outputs are registered and decoded from the next state, so they are valid in the first cycle of the new state.
- Reset values:
  - link_state=1;
  - mgt_tx_reset=mgt_rx_reset=4'hF;
  - enable_align=0, en_chan_sync=0;
  - mgt_loopback=0, mgt_powerdown=0;
  - link_up=0, retry_count=0.
- When reset_n asserts mid-operation, all outputs go to their reset values asynchronously.
- Inputs are sampled on the rising edge. A transition occurs on the edge where its condition is sampled true.
- Minimum bring-up time, with all conditions met immediately: RESET_CYCLES + 1 (WAIT_LOCK) + ALIGN_GOOD + 1 (SYNC) cycles from reset release to link_up=1. With defaults this is 82 cycles.
- Drop latency: link_up falls 1 cycle after a fatal condition is sampled in UP. For code errors it falls ERR_LIMIT cycles after the first error.

## Test plan
- Clean bring-up: all inputs good from reset release. Required: link_up=1 at cycle 82, retry_count=0, tx/rx reset low from cycle 16.
- Lock timeout: LOCK_TIMEOUT=64 and rxlock held 0. Required: return to RST every 16+64 cycles and retry_count increments each time. Force 300 failures; retry_count must saturate at 8'hFF.
- Align glitch: code_valid drops for one cycle at good-run count 63. Required: the counter restarts and SYNC is entered 64 cycles after the glitch.
- UP error filter: 7 consecutive error cycles, then valid. Required: link stays up. Then 8 consecutive error cycles. Required: link_up=0 on the 9th edge and retry_count+1.
- Loopback change and force_retrain while UP. Required: RST entered next cycle, retry_count unchanged, mgt_loopback follows cfg_loopback.
- cfg_powerdown asserted in ALIGN, then reset_n pulsed mid-SYNC. Required: PD with powerdown=1 and resets=4'hF next cycle. On reset_n low, all outputs take their reset values immediately.
